// File: rtl/data_sram_like_bridge.sv
// MEM-stage data port bridge to an sram-like bus: one transaction per access,
// stalls the pipeline until data_ok and holds the read word while frozen by others.
module data_sram_like_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        stall_others,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {StIdle, StWaitAddr, StWaitData, StHold} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_strb;

  logic [1:0]  w_size;
  logic [1:0]  w_lo;
  logic [31:0] w_dec_addr;
  logic        w_unused;

  // Low address bits come from the byte-enable pattern, not from data_addr.
  assign w_unused = ^data_addr[1:0];

  always_comb begin
    w_size = 2'd2;
    w_lo   = 2'b00;
    case (data_wen)
      4'b0011: begin w_size = 2'd1; w_lo = 2'b00; end
      4'b1100: begin w_size = 2'd1; w_lo = 2'b10; end
      4'b0001: begin w_size = 2'd0; w_lo = 2'b00; end
      4'b0010: begin w_size = 2'd0; w_lo = 2'b01; end
      4'b0100: begin w_size = 2'd0; w_lo = 2'b10; end
      4'b1000: begin w_size = 2'd0; w_lo = 2'b11; end
      default: ;
    endcase
  end

  assign w_dec_addr = {data_addr[31:2], w_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_strb  <= 4'd0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle && data_en) begin
        r_addr  <= w_dec_addr;
        r_wdata <= data_wdata;
        r_wr    <= |data_wen;
        r_size  <= w_size;
        r_strb  <= data_wen;
      end
      if (r_state == StWaitData && data_data_ok) begin
        r_rdata <= data_rdata_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:     if (data_en) w_state_nxt = data_addr_ok ? StWaitData : StWaitAddr;
      StWaitAddr: if (data_addr_ok) w_state_nxt = StWaitData;
      StWaitData: if (data_data_ok) w_state_nxt = stall_others ? StHold : StIdle;
      StHold:     if (!stall_others) w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    data_req = 1'b0;
    d_stall  = 1'b0;
    case (r_state)
      StIdle:     begin data_req = data_en; d_stall = data_en; end
      StWaitAddr: begin data_req = 1'b1;    d_stall = 1'b1;    end
      StWaitData: d_stall = ~data_data_ok;
      default:    ;
    endcase
    if (rst) begin
      data_req = 1'b0;
      d_stall  = 1'b0;
    end
    data_rdata = (r_state == StWaitData) ? data_rdata_i : r_rdata;
    // Re-issued requests present the fields captured at issue time.
    if (r_state == StWaitAddr) begin
      data_wr      = r_wr;
      data_size    = r_size;
      data_addr_o  = r_addr;
      data_wdata_o = r_wdata;
      data_wstrb   = r_strb;
    end else begin
      data_wr      = |data_wen;
      data_size    = w_size;
      data_addr_o  = w_dec_addr;
      data_wdata_o = data_wdata;
      data_wstrb   = data_wen;
    end
  end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Randomized bench for data_sram_like_bridge; expected bus fields and stall/req
// timing are computed from access-level rules (latencies, byte-enable shape).
module tb_data_sram_like_bridge;

  logic        clk, rst;
  logic        data_en, stall_others;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd;

  data_sram_like_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .data_en     (data_en),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .stall_others(stall_others),
    .data_rdata  (data_rdata),
    .d_stall     (d_stall),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr_o (data_addr_o),
    .data_wdata_o(data_wdata_o),
    .data_wstrb  (data_wstrb),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata_i(data_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus size and address from the shape of the byte-enable pattern.
  function automatic logic [33:0] exp_bus(input logic [3:0] wen, input logic [31:0] addr);
    int n, lo;
    n  = $countones(wen);
    lo = 0;
    for (int i = 3; i >= 0; i--) if (wen[i]) lo = i;
    if (n == 1) return {2'd0, addr[31:2], 2'(lo)};
    if (n == 2 && (wen >> lo) == 4'b0011 && (lo % 2) == 0) return {2'd1, addr[31:2], 2'(lo)};
    return {2'd2, addr[31:2], 2'b00};
  endfunction

  task automatic test_reset();
    rst = 1'b1; data_en = 1'b1; data_wen = 4'b0100; data_addr = 32'h8000_0012;
    data_wdata = 32'h5555_aaaa; data_addr_ok = 1'b1; data_data_ok = 1'b1;
    data_rdata_i = 32'hdead_beef; stall_others = 1'b0;
    #12;
    n_vec++;
    if ({data_req, d_stall} !== 2'b00) begin
      n_err++; $display("FAIL reset_req_stall: got %b expected 00", {data_req, d_stall});
    end
    n_vec++;
    if (data_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h expected 0", data_rdata);
    end
    n_vec++;
    if ({data_wr, data_size, data_addr_o, data_wstrb} !== {1'b1, 2'd0, 32'h8000_0012, 4'b0100})
    begin
      n_err++; $display("FAIL reset_decode: got %b %0d %h %b expected 1 0 80000012 0100",
                        data_wr, data_size, data_addr_o, data_wstrb);
    end
    @(posedge clk); #1;
    rst = 1'b0; data_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic test_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      data_en = 1'b0; data_wen = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      data_addr_ok = 1'b0; data_data_ok = 1'($urandom); data_rdata_i = $urandom;
      stall_others = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if ({data_req, d_stall, data_rdata} !== {2'b00, last_rd}) begin
        n_err++; $display("FAIL idle: got req/stall %b rdata %h expected 00 %h",
                          {data_req, d_stall}, data_rdata, last_rd);
      end
      @(posedge clk); #1;
    end
  endtask

  // One access: addr_ok la cycles after issue, data_ok ld cycles after addr_ok.
  task automatic test_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rd,
                             input int la, input int ld, input bit stall_ok, input int hs);
    logic [33:0] e_bus;
    logic        e_req, e_stall;
    int          n_acc;
    e_bus = exp_bus(wen, addr);
    n_acc = 0;
    for (int c = 0; c <= la + ld; c++) begin
      if (c == 0) begin
        data_en = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
      end else begin
        data_en = 1'($urandom); data_wen = 4'($urandom);
        data_addr = $urandom; data_wdata = $urandom;
      end
      data_addr_ok = (c == la);
      data_data_ok = (c == la + ld);
      data_rdata_i = (c == la + ld) ? rd : $urandom;
      stall_others = (c == la + ld) ? stall_ok : 1'($urandom);
      @(negedge clk);
      e_req   = (c <= la);
      e_stall = (c < la + ld);
      n_vec++;
      if ({data_req, d_stall} !== {e_req, e_stall}) begin
        n_err++; $display("FAIL access_req_stall cyc %0d: got %b expected %b",
                          c, {data_req, d_stall}, {e_req, e_stall});
      end
      if (c <= la) begin
        if (data_req && data_addr_ok) n_acc++;
        n_vec++;
        if ({data_wr, data_size, data_addr_o, data_wdata_o, data_wstrb}
            !== {|wen, e_bus, wdata, wen}) begin
          n_err++; $display("FAIL access_fields cyc %0d: got %b %0d %h %h %b expected %b %0d %h %h %b",
                            c, data_wr, data_size, data_addr_o, data_wdata_o, data_wstrb,
                            |wen, e_bus[33:32], e_bus[31:0], wdata, wen);
        end
        n_vec++;
        if (data_rdata !== last_rd) begin
          n_err++; $display("FAIL access_old_rdata cyc %0d: got %h expected %h",
                            c, data_rdata, last_rd);
        end
      end
      if (c == la + ld) begin
        n_vec++;
        if (data_rdata !== rd) begin
          n_err++; $display("FAIL access_rdata: got %h expected %h", data_rdata, rd);
        end
      end
      @(posedge clk); #1;
    end
    last_rd = rd;
    n_vec++;
    if (n_acc != 1) begin
      n_err++; $display("FAIL access_count: got %0d expected 1", n_acc);
    end
    if (stall_ok) begin
      for (int h = 0; h <= hs; h++) begin
        data_en = 1'($urandom); data_wen = 4'($urandom); data_addr = $urandom;
        data_addr_ok = 1'b0; data_data_ok = 1'($urandom); data_rdata_i = $urandom;
        stall_others = (h < hs);
        @(negedge clk);
        n_vec++;
        if ({data_req, d_stall, data_rdata} !== {2'b00, rd}) begin
          n_err++; $display("FAIL hold h %0d: got req/stall %b rdata %h expected 00 %h",
                            h, {data_req, d_stall}, data_rdata, rd);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0100; data_wdata = $urandom;
    data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata_i = $urandom; stall_others = 1'b0;
    @(posedge clk); #1;
    data_en = 1'b0; data_addr_ok = 1'b0; data_rdata_i = 32'h7777_1234;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({data_req, d_stall, data_rdata} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL reset_mid: got req/stall %b rdata %h expected 00 0",
                        {data_req, d_stall}, data_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    data_data_ok = 1'b1; data_rdata_i = 32'hcafe_f00d;
    @(negedge clk);
    n_vec++;
    if ({data_req, d_stall, data_rdata} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL late_data_ok: got req/stall %b rdata %h expected 00 0",
                        {data_req, d_stall}, data_rdata);
    end
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    last_rd = 32'h0;
    test_idle(1);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_access(4'b0000, 32'h8000_0006, $urandom, 32'h1122_3344, 0, 1, 1'b0, 0);
    test_access(4'b0100, 32'h8000_0012, 32'hABAB_ABAB, $urandom, 0, 1, 1'b0, 0);
    test_access(4'b1111, $urandom, $urandom, $urandom, 3, 2, 1'b0, 0);
    test_access(4'b0000, $urandom, $urandom, 32'h5a5a_0f0f, 0, 1, 1'b1, 3);
    test_access(4'b0011, $urandom, $urandom, $urandom, 0, 1, 1'b0, 0);
    test_access(4'b1110, 32'h8000_0001, $urandom, $urandom, 1, 1, 1'b0, 0);
    test_idle(2);
    test_reset_mid();
    test_access(4'b1000, $urandom, $urandom, $urandom, 0, 1, 1'b0, 0);
    for (int i = 0; i < 60; i++) begin
      test_idle(int'($urandom_range(0, 2)));
      test_access(4'($urandom), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                  1'($urandom), int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
